if_id_buf: RTL and testbench

Elastic IF→ID pipeline buffer. It sits between the fetch stage and the decode stage `id`, and holds fetched {pc, instruction} pairs in a small FIFO. It decouples fetch from decode stalls, supports branch flush from EX, and presents a NOP bubble to `id` whenever it is empty.

---
 rtl/if_id_buf.sv | 104 ++++++++++
 tb/tb_if_id_buf.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - elastic IF->ID buffer presenting a NOP bubble when empty
// Optional perf counters enabled by defining IF_ID_BUF_PERF_EN.
module if_id_buf #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          AW       = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [31:0]   i_pc_addr,
  input  logic [31:0]   i_inst_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [31:0]   o_pc_addr,
  output logic [31:0]   o_inst_data,
  output logic          o_valid,
  input  logic          i_ready,
  input  logic          i_flush,
  output logic [AW:0]   o_count,
  output logic [31:0]   o_stall_cycles,
  output logic [31:0]   o_flush_drops
);

  localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;

  logic w_valid;
  logic w_ready;
  logic w_push;
  logic w_pop;

  // Handshake flags come only from registered count, so i_ready never reaches o_ready.
  assign w_valid = (r_count != '0);
  assign w_ready = (r_count != LP_DEPTH);
  assign w_push  = i_valid & w_ready & ~i_flush;
  assign w_pop   = w_valid & i_ready & ~i_flush;

  assign o_valid     = w_valid;
  assign o_ready     = w_ready;
  assign o_count     = r_count;
  assign o_pc_addr   = w_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;
  assign o_inst_data = w_valid ? r_mem_inst[r_rd_ptr] : NOP_INST;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= i_pc_addr;
      r_mem_inst[r_wr_ptr] <= i_inst_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (i_flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IF_ID_BUF_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_drops;
  logic [32:0] w_drops_sum;

  assign w_drops_sum = {1'b0, r_flush_drops} + 33'(r_count);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cycles <= '0;
      r_flush_drops  <= '0;
    end else begin
      if (w_valid && !i_ready && !i_flush && (r_stall_cycles != 32'hFFFFFFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (i_flush)
        r_flush_drops <= w_drops_sum[32] ? 32'hFFFFFFFF : w_drops_sum[31:0];
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_drops  = r_flush_drops;
`else
  assign o_stall_cycles = 32'h0;
  assign o_flush_drops  = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - scoreboard bench for if_id_buf
module tb_if_id_buf;

  localparam int          DEPTH = 2;
  localparam int          AW    = 1;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef IF_ID_BUF_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic [31:0]   i_pc_addr;
  logic [31:0]   i_inst_data;
  logic          i_valid;
  logic          o_ready;
  logic [31:0]   o_pc_addr;
  logic [31:0]   o_inst_data;
  logic          o_valid;
  logic          i_ready;
  logic          i_flush;
  logic [AW:0]   o_count;
  logic [31:0]   o_stall_cycles;
  logic [31:0]   o_flush_drops;

  if_id_buf #(.DEPTH(DEPTH), .NOP_INST(NOP), .AW(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_pc_addr(i_pc_addr), .i_inst_data(i_inst_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_pc_addr(o_pc_addr), .o_inst_data(o_inst_data), .o_valid(o_valid), .i_ready(i_ready),
    .i_flush(i_flush), .o_count(o_count),
    .o_stall_cycles(o_stall_cycles), .o_flush_drops(o_flush_drops)
  );

  always #5 i_clk = ~i_clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_drops = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Offer one pair; the expected output is queued at the cycle it is accepted.
  task automatic put(input logic [31:0] pc, input logic [31:0] inst);
    bit ok;
    ok = 1'b0;
    i_valid = 1'b1;
    i_pc_addr = pc;
    i_inst_data = inst;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge i_clk);
      if (o_ready && !i_flush) begin
        exp_q.push_back({pc, inst});
        ok = 1'b1;
      end
      step();
    end
    check("put_accept", 32'(ok), 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(o_count), 32'd0);
  endtask

  always @(negedge i_clk) begin
    if (mon_en && i_reset_n) begin
      check("count_bound", 32'(o_count <= (AW+1)'(DEPTH)), 32'd1);
      if (!o_valid) begin
        check("bubble_inst", o_inst_data, NOP);
        check("bubble_pc", o_pc_addr, 32'h0);
      end
      if (i_flush) begin
        exp_drops = exp_drops + 32'(o_count);
        exp_q.delete();
      end else if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", o_pc_addr, 32'hDEAD_BEEF);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("out_pc", o_pc_addr, e[63:32]);
          check("out_inst", o_inst_data, e[31:0]);
        end
      end else if (o_valid && !i_ready) begin
        exp_stall = exp_stall + 32'd1;
      end
    end
  end

  initial begin
    i_reset_n = 1'b0;
    i_pc_addr = '0;
    i_inst_data = '0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_flush = 1'b0;
    repeat (3) step();
    i_reset_n = 1'b1;
    mon_en = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_inst", o_inst_data, NOP);
      check("rst_pc", o_pc_addr, 32'h0);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_count", 32'(o_count), 32'd0);
    end
    step();

    i_ready = 1'b1;
    put(32'h0, 32'h00500093);
    put(32'h4, 32'h00A00113);
    put(32'h8, 32'h002081B3);
    @(negedge i_clk);
    check("stream_count", 32'(o_count), 32'd1);
    check("stream_valid", 32'(o_valid), 32'd1);
    step();
    drain();
    check("stream_drops", o_flush_drops, 32'h0);

    i_ready = 1'b0;
    put(32'h10, 32'h11111111);
    put(32'h14, 32'h22222222);
    i_valid = 1'b1;
    i_pc_addr = 32'h18;
    i_inst_data = 32'h33333333;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      check("full_count", 32'(o_count), 32'd2);
      check("full_ready", 32'(o_ready), 32'd0);
      step();
    end
    i_ready = 1'b1;
    put(32'h18, 32'h33333333);
    drain();

    for (int k = 0; k < 6; k++) begin
      i_ready = k[0];
      put(32'h20 + 32'(4 * k), 32'h1000_0000 | 32'(k));
    end
    drain();

    i_ready = 1'b0;
    put(32'h30, 32'h44444444);
    put(32'h34, 32'h55555555);
    i_valid = 1'b1;
    i_pc_addr = 32'h40;
    i_inst_data = 32'h66666666;
    i_ready = 1'b1;
    i_flush = 1'b1;
    @(negedge i_clk);
    check("flush_pre_count", 32'(o_count), 32'd2);
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_inst", o_inst_data, NOP);
    check("flush_count", 32'(o_count), 32'd0);
    check("flush_ready", 32'(o_ready), 32'd1);
    check("flush_drops", o_flush_drops, PERF ? exp_drops : 32'h0);
    step();
    drain();

    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge i_clk);
    check("empty_flush_drops", o_flush_drops, PERF ? exp_drops : 32'h0);
    step();

    i_ready = 1'b0;
    put(32'h50, 32'h77777777);
    repeat (5) step();
    @(negedge i_clk);
    check("pre_rst_count", 32'(o_count), 32'd1);
    check("stall_cycles", o_stall_cycles, PERF ? exp_stall : 32'h0);
    #2;
    i_reset_n = 1'b0;
    exp_q.delete();
    exp_stall = 0;
    exp_drops = 0;
    #1;
    check("async_valid", 32'(o_valid), 32'd0);
    check("async_count", 32'(o_count), 32'd0);
    check("async_ready", 32'(o_ready), 32'd1);
    check("async_inst", o_inst_data, NOP);
    check("async_pc", o_pc_addr, 32'h0);
    check("async_stall", o_stall_cycles, 32'h0);
    check("async_drops", o_flush_drops, 32'h0);
    step();
    i_reset_n = 1'b1;
    i_ready = 1'b1;
    put(32'h60, 32'h88888888);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
